// File: rtl/cfg_pkg.sv
// Shared tile configuration constants and loader state encoding.
// Imported by the configuration writer and anything sizing the tile config bus.
package cfg_pkg;

    localparam int LE_CONFIG_WIDTH    = 17;
    localparam int LE_COUNT           = 2;
    localparam int SB_CONFIG_WIDTH    = 160;
    localparam int TILE_CONFIG_WIDTH  = LE_COUNT * LE_CONFIG_WIDTH + SB_CONFIG_WIDTH;
    localparam int DEFAULT_WORD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/config_loader.sv
// Streams bitstream words into a shadow register and commits the full
// configuration to the tile bus in one edge, so the tile never sees a partial load.
module config_loader
    import cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = TILE_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done,
    output logic                    busy,
    output logic [$clog2((CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH)-1:0] word_index
);

    localparam int NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    loader_state_t           state;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic [CONFIG_WIDTH-1:0] merged;
    logic                    handshake;

    assign handshake = data_valid & data_ready;

    // Bits of the final word that land past the bus width simply have no slot.
    always_comb begin
        merged = shadow;
        for (int i = 0; i < CONFIG_WIDTH; i++) begin
            if (i / WORD_WIDTH == int'(word_index)) begin
                merged[i] = data_in[i % WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= '0;
            config_out  <= '0;
            word_index  <= '0;
            config_done <= 1'b0;
            busy        <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= LOAD;
                        shadow     <= '0;
                        word_index <= '0;
                        busy       <= 1'b1;
                        data_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        shadow     <= '0;
                        word_index <= '0;
                        busy       <= 1'b0;
                        data_ready <= 1'b0;
                    end else if (handshake) begin
                        if (word_index == LAST_IDX) begin
                            state       <= DONE;
                            config_out  <= merged;
                            config_done <= 1'b1;
                            word_index  <= '0;
                            busy        <= 1'b0;
                            data_ready  <= 1'b0;
                        end else begin
                            shadow     <= merged;
                            word_index <= word_index + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    data_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Randomised and directed checks of config_loader against a word-list model.
// The model keeps accepted words in an array and assembles the bus on completion.
module tb_config_loader;

    localparam int CW = 194;
    localparam int NW = 25;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          data_ready;
    logic [CW-1:0] config_out;
    logic          config_done;
    logic          busy;
    logic [4:0]    word_index;

    int n_checks;
    int n_fail;

    logic          m_load;
    logic          m_done;
    logic [CW-1:0] m_cfg;
    int            m_cnt;
    logic [7:0]    m_words [NW];

    config_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .config_out  (config_out),
        .config_done (config_done),
        .busy        (busy),
        .word_index  (word_index)
    );

    always #5 clock = ~clock;

    task automatic step(input logic r, input logic s, input logic a,
                        input logic v, input logic [7:0] d);
        reset      = r;
        start      = s;
        abort      = a;
        data_valid = v;
        data_in    = d;
        @(posedge clock);
        if (r) begin
            m_load = 0;
            m_done = 0;
            m_cfg  = '0;
            m_cnt  = 0;
        end else if (m_load) begin
            if (a) begin
                m_load = 0;
                m_cnt  = 0;
            end else if (v) begin
                m_words[m_cnt] = d;
                m_cnt++;
                if (m_cnt == NW) begin
                    for (int j = 0; j < CW; j++) m_cfg[j] = m_words[j / 8][j % 8];
                    m_done = 1;
                    m_load = 0;
                    m_cnt  = 0;
                end
            end
        end else if (s) begin
            m_load = 1;
            m_cnt  = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'hA5);
        n_checks++;
        if (config_out !== '0) begin
            n_fail++;
            $display("FAIL reset_config got=%h want=0", config_out);
        end
        n_checks++;
        if ({config_done, busy, data_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000", {config_done, busy, data_ready});
        end
        n_checks++;
        if (word_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_index got=%0d want=0", word_index);
        end
        step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_full_load();
        int busy_cycles = 0;
        step(0, 1, 0, 0, 8'h00);
        if (busy) busy_cycles++;
        for (int k = 0; k < NW; k++) begin
            step(0, 0, 0, 1, 8'(k));
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (busy_cycles !== 25) begin
            n_fail++;
            $display("FAIL full_busy_cycles got=%0d want=25", busy_cycles);
        end
        n_checks++;
        if (config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done got=%b want=1", config_done);
        end
        n_checks++;
        if (config_out[7:0] !== 8'h00 || config_out[15:8] !== 8'h01) begin
            n_fail++;
            $display("FAIL full_low_bytes got=%h want=0100", config_out[15:0]);
        end
        n_checks++;
        if (config_out[191:184] !== 8'h17 || config_out[193:192] !== 2'b00) begin
            n_fail++;
            $display("FAIL full_high_bits got=%h want=017", config_out[193:184]);
        end
        n_checks++;
        if (config_out !== m_cfg) begin
            n_fail++;
            $display("FAIL full_model got=%h want=%h", config_out, m_cfg);
        end
    endtask

    task automatic test_all_ones_toggle();
        int cycles = 0;
        int hs = 0;
        logic v = 1;
        step(0, 1, 0, 0, 8'h00);
        while (hs < NW && cycles < 200) begin
            step(0, 0, 0, v, 8'hFF);
            cycles++;
            if (v) hs++;
            v = ~v;
        end
        n_checks++;
        if (cycles !== 49) begin
            n_fail++;
            $display("FAIL ones_cycles got=%0d want=49", cycles);
        end
        n_checks++;
        if (config_out !== {CW{1'b1}} || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ones_config got=%h done=%b want all ones, 1", config_out, config_done);
        end
    endtask

    task automatic test_abort();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 8'($urandom));
        n_checks++;
        if (word_index !== 5'd10) begin
            n_fail++;
            $display("FAIL abort_pre_index got=%0d want=10", word_index);
        end
        step(0, 0, 1, 0, 8'h00);
        n_checks++;
        if ({busy, data_ready} !== 2'b00 || word_index !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_state got=%b idx=%0d want=00 idx=0", {busy, data_ready}, word_index);
        end
        n_checks++;
        if (config_out !== {CW{1'b1}} || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_keep got=%h done=%b want all ones, 1", config_out, config_done);
        end
        step(0, 0, 0, 1, 8'h3C);
        n_checks++;
        if (data_ready !== 1'b0 || word_index !== 5'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_valid ready=%b idx=%0d busy=%b want 0 0 0",
                     data_ready, word_index, busy);
        end
    endtask

    task automatic test_reload();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < NW - 1; k++) step(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (config_out !== {CW{1'b1}}) begin
            n_fail++;
            $display("FAIL reload_hold got=%h want all ones", config_out);
        end
        step(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (config_out !== '0 || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_commit got=%h done=%b want 0, 1", config_out, config_done);
        end
    endtask

    task automatic test_reset_mid_load();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < NW; k++) step(0, 0, 0, 1, 8'($urandom));
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 8'($urandom));
        step(1, 0, 0, 1, 8'h77);
        n_checks++;
        if (config_out !== '0 || config_done !== 1'b0 || word_index !== 5'd0
            || busy !== 1'b0 || data_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset got cfg=%h done=%b idx=%0d busy=%b rdy=%b want all 0",
                     config_out, config_done, word_index, busy, data_ready);
        end
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 200 && m_load; k++) step(0, 0, 0, 1'($urandom), 8'($urandom));
        n_checks++;
        if (config_out !== m_cfg || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_reload got=%h want=%h", config_out, m_cfg);
        end
    endtask

    task automatic test_start_in_load();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'($urandom));
        step(0, 1, 0, 1, 8'($urandom));
        n_checks++;
        if (word_index !== 5'd6 || word_index !== 5'(m_cnt)) begin
            n_fail++;
            $display("FAIL start_in_load got=%0d want=6", word_index);
        end
        step(0, 0, 0, 1, 8'($urandom));
        n_checks++;
        if (word_index !== 5'd7) begin
            n_fail++;
            $display("FAIL start_in_load_next got=%0d want=7", word_index);
        end
        for (int k = 0; k < 200 && m_load; k++) step(0, 0, 0, 1, 8'($urandom));
        n_checks++;
        if (config_out !== m_cfg) begin
            n_fail++;
            $display("FAIL start_in_load_commit got=%h want=%h", config_out, m_cfg);
        end
    endtask

    task automatic test_abort_handshake();
        step(0, 1, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'hAA);
        step(0, 0, 1, 1, 8'h55);
        n_checks++;
        if (word_index !== 5'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hs got idx=%0d busy=%b want 0 0", word_index, busy);
        end
        step(0, 1, 1, 0, 8'h00);
        n_checks++;
        if (busy !== 1'b1 || data_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_abort_idle got busy=%b rdy=%b want 1 1", busy, data_ready);
        end
        step(0, 0, 1, 0, 8'h00);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step(0, ($urandom % 4) == 0, ($urandom % 64) == 0,
                 1'($urandom), 8'($urandom));
            n_checks++;
            if (config_out !== m_cfg || config_done !== m_done || busy !== m_load
                || data_ready !== m_load || word_index !== 5'(m_cnt)) begin
                n_fail++;
                $display("FAIL random c=%0d cfg=%h/%h done=%b/%b busy=%b/%b rdy=%b idx=%0d/%0d",
                         c, config_out, m_cfg, config_done, m_done, busy, m_load,
                         data_ready, word_index, m_cnt);
            end
        end
    endtask

    initial begin
        clock      = 0;
        reset      = 1;
        start      = 0;
        abort      = 0;
        data_in    = '0;
        data_valid = 0;
        n_checks   = 0;
        n_fail     = 0;
        m_load     = 0;
        m_done     = 0;
        m_cfg      = '0;
        m_cnt      = 0;
        test_reset();
        test_full_load();
        test_all_ones_toggle();
        test_abort();
        test_reload();
        test_reset_mid_load();
        test_start_in_load();
        test_abort_handshake();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Writer side of the tile configuration interface.
- Accepts a configuration bitstream as a stream of WORD_WIDTH-bit words over a valid/ready handshake and assembles them in a shadow register.
- Commits the assembled word atomically onto the parallel config bus that feeds a LogicTile's config_in.
- Sits between the external programming port and one tile; config_out never shows a partially loaded bitstream.

Parameters:
- CONFIG_WIDTH, 194, width of the tile config bus (2 x 17 LE bits + 160 switchbox bits).
- WORD_WIDTH, 8, width of one bitstream word on data_in.
- NUM_WORDS, ceil(CONFIG_WIDTH/WORD_WIDTH) = 25, derived localparam, not overridable.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; honoured in IDLE and DONE.
- abort  input  1  in LOAD, discards the partial load and returns to IDLE.
- data_in  input  WORD_WIDTH  bitstream word.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  loader can accept a word this cycle.
- config_out  output  CONFIG_WIDTH  committed configuration, drives LogicTile config_in.
- config_done  output  1  config_out holds a complete committed bitstream.
- busy  output  1  high in LOAD.
- word_index  output  $clog2(NUM_WORDS)  index of the next word expected.

Behaviour:
- Reset, taking priority over everything:
  - state IDLE; shadow, config_out, word_index cleared to 0.
  - config_done=0, busy=0, data_ready=0.
- States:
  - IDLE: data_ready=0. start -> LOAD; shadow and word_index cleared on the same edge.
  - LOAD:
    - data_ready=1, busy=1.
    - Handshake = data_valid & data_ready.
    - Word k is written to shadow bits [k*WORD_WIDTH+WORD_WIDTH-1 : k*WORD_WIDTH]. Bits at or above CONFIG_WIDTH are dropped (last word: only data_in[1:0] used at defaults).
    - word_index increments per handshake.
  - Final handshake (word_index==NUM_WORDS-1):
    - config_out <= shadow merged with the final word, on the same edge.
    - state -> DONE; word_index -> 0; config_done <= 1.
    - Latency: new config visible the cycle after the last handshake.
  - DONE:
    - data_ready=0, busy=0.
    - start -> LOAD. config_out keeps the old value until the next commit; config_done stays 1 (sticky until reset).
- Abort:
  - abort in LOAD -> IDLE next edge; shadow discarded.
  - config_out and config_done unchanged.
  - A handshake in the same cycle as abort is discarded (abort wins).
  - Abort outside LOAD is ignored.
- start in LOAD is ignored; restarting a load requires abort, then start.
- data_valid while data_ready=0: no effect, no word consumed.
- Simultaneous start and abort in IDLE/DONE: start is honoured.
- data_ready depends only on state (registered), with no combinational path from inputs.
- Reset mid-LOAD clears everything, including a previously committed config_out.

Decomposition:
- Shared package cfg_pkg contains:
  - tile config constants: TILE_CONFIG_WIDTH=194, LE_CONFIG_WIDTH=17, SB_CONFIG_WIDTH=160, LE_COUNT=2, default WORD_WIDTH=8;
  - loader state enum {IDLE, LOAD, DONE}.
- No sub-module: one FSM, the index counter, and the shadow/commit registers in a single module.

Test Plan:
- Full load, words 0x00..0x18, data_valid held high:
  - busy high for 25 cycles;
  - after commit config_out[7:0]=0x00, [15:8]=0x01, [191:184]=0x17, [193:192]=2'b00 (0x18&3);
  - config_done=1 the cycle after the 25th handshake.
- All-ones load, 25 words of 0xFF with data_valid toggling 1,0,1,0:
  - 25 handshakes in 49 cycles;
  - config_out all 194 bits =1; upper 6 bits of the last word ignored, no error.
- Abort after 10 words, following a prior all-ones commit:
  - state IDLE; config_out still all ones; config_done still 1;
  - subsequent data_valid sees data_ready=0.
- Reload in DONE:
  - start, then 24 words of 0x00: config_out unchanged (all ones);
  - 25th word 0x00: config_out=0 the cycle after.
- Reset asserted at word 12 of a load:
  - next cycle config_out=0, config_done=0, word_index=0, state IDLE;
  - start and 25 words then load correctly.
- Edge cases:
  - start during LOAD at word 5: ignored, word_index continues 6,7,...;
  - abort with a same-cycle handshake: word not written, word_index returns to 0.
